// File: rtl/ppr_seq_cpa_if.sv
// ---------------------------------------------------------------------------
// ppr_seq_cpa_if
// Handshake bundle for the sequential carry-propagate adder.
//   in_valid / in_ready    : operand-pair handshake (upstream -> adder)
//   sum_vec / carry_vec    : redundant operands from the compressor tree
//   out_valid / out_ready  : result handshake (adder -> consumer)
//   result / cout          : resolved binary sum and carry out of the MSB
//   zero                   : result==0 flag, present only when
//                            PPR_CPA_ZERO_FLAG_EN is defined
// Modports: master = upstream/consumer side, slave = the adder.
// ---------------------------------------------------------------------------
interface ppr_seq_cpa_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

`ifdef PPR_CPA_ZERO_FLAG_EN
  logic             zero;

  modport master (
    output in_valid, sum_vec, carry_vec, out_ready,
    input  in_ready, out_valid, result, cout, zero
  );

  modport slave (
    input  in_valid, sum_vec, carry_vec, out_ready,
    output in_ready, out_valid, result, cout, zero
  );
`else
  modport master (
    output in_valid, sum_vec, carry_vec, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, sum_vec, carry_vec, out_ready,
    output in_ready, out_valid, result, cout
  );
`endif
endinterface

// File: rtl/ppr_seq_cpa.sv
// ---------------------------------------------------------------------------
// ppr_seq_cpa
// Final carry-propagate adder behind the 4:2 compressor tree. Resolves the
// redundant sum/carry vectors SLICE bits per cycle; the inter-slice carry is
// held in a register, so there is no combinational path across slices.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; aborts any operation in flight
//   bus    : ppr_seq_cpa_if.slave (operand and result handshakes)
//
// Parameters: WIDTH (multiple of SLICE), SLICE (bits resolved per cycle).
// Optional feature: define PPR_CPA_ZERO_FLAG_EN to drive bus.zero, a
// result==0 flag valid in DONE, built from a per-slice sticky flag.
// ---------------------------------------------------------------------------
module ppr_seq_cpa #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic          clk,
  input logic          reset,
  ppr_seq_cpa_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             cy_q;
  logic [WIDTH-1:0] sum_op_q;
  logic [WIDTH-1:0] carry_op_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             in_ready;
  logic             out_valid;
  int               base;
  logic [SLICE:0]   slice_sum;

  // Slice adder: one SLICE-bit slice of each operand plus the carry register.
  always_comb begin
    base      = int'(idx_q) * SLICE;
    slice_sum = {1'b0, sum_op_q[base +: SLICE]}
              + {1'b0, carry_op_q[base +: SLICE]}
              + {{SLICE{1'b0}}, cy_q};
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = ADD;
      end
      ADD: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sum_op_q   <= bus.sum_vec;
            carry_op_q <= bus.carry_vec;
            cy_q       <= 1'b0;
            idx_q      <= '0;
          end
        end
        ADD: begin
          result_q[base +: SLICE] <= slice_sum[SLICE-1:0];
          cy_q                    <= slice_sum[SLICE];
          idx_q                   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) cout_q <= slice_sum[SLICE];
        end
        default: ;
      endcase
    end
  end

`ifdef PPR_CPA_ZERO_FLAG_EN
  // Sticky all-zero flag: set on acceptance, cleared by any nonzero slice.
  logic zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
    end else if (state_q == IDLE && bus.in_valid) begin
      zero_q <= 1'b1;
    end else if (state_q == ADD) begin
      zero_q <= zero_q & ~(|slice_sum[SLICE-1:0]);
    end
  end

  assign bus.zero = (state_q == DONE) & zero_q;
`else
  // No zero flag in this build.
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_ppr_seq_cpa.sv
// ---------------------------------------------------------------------------
// tb_ppr_seq_cpa
// Directed bench for ppr_seq_cpa (WIDTH=16, SLICE=4): reset state, basic
// add, cross-slice ripple, output backpressure, busy-input ignore, reset
// mid-operation and a short run of $urandom operand pairs checked against
// a 17-bit reference sum. Optional zero flag checked under
// PPR_CPA_ZERO_FLAG_EN.
// ---------------------------------------------------------------------------
module tb_ppr_seq_cpa;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  ppr_seq_cpa_if #(.WIDTH(16)) bus ();

  ppr_seq_cpa #(
    .WIDTH(16),
    .SLICE(4)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full transaction: accept, wait for out_valid, hold for 'hold'
  // cycles with out_ready low, then release.
  task automatic do_op(input logic [15:0] s, input logic [15:0] c, input int hold);
    logic [16:0] exp;
    int          cyc;
    exp = {1'b0, s} + {1'b0, c};
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.sum_vec   = s;
    bus.carry_vec = c;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.sum_vec   = ~s;
    bus.carry_vec = ~c;
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd4);
    chk("result", 32'(bus.result), 32'(exp[15:0]));
    chk("cout", 32'(bus.cout), 32'(exp[16]));
`ifdef PPR_CPA_ZERO_FLAG_EN
    chk("zero", 32'(bus.zero), 32'(exp[15:0] == 16'h0));
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", 32'(bus.result), 32'(exp[15:0]));
      chk("hold_cout", 32'(bus.cout), 32'(exp[16]));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int          cyc;
    logic [15:0] rs;
    logic [15:0] rc;
    passed        = 0;
    total         = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum_vec   = 16'h0;
    bus.carry_vec = 16'h0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef PPR_CPA_ZERO_FLAG_EN
    chk("rst_zero", 32'(bus.zero), 32'd0);
`endif
    reset = 1'b0;

    // Basic add, with 3 cycles of output backpressure
    do_op(16'h1234, 16'h4321, 3);   // 0x5555, cout 0
    // Cross-slice ripple
    do_op(16'hFFFF, 16'h0001, 0);   // 0x0000, cout 1
    do_op(16'h00FF, 16'h0001, 1);   // 0x0100, cout 0
    do_op(16'h8000, 16'h8000, 0);   // 0x0000, cout 1

    // Input ignored while busy
    bus.sum_vec   = 16'h0001;
    bus.carry_vec = 16'h0001;
    bus.in_valid  = 1'b1;
    tick();
    bus.sum_vec   = 16'hAAAA;
    bus.carry_vec = 16'h5555;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("busy_latency", 32'(cyc), 32'd4);
    chk("busy_result", 32'(bus.result), 32'h0002);
    chk("busy_cout", 32'(bus.cout), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    repeat (6) tick();
    chk("busy_no_extra", 32'(bus.out_valid), 32'd0);

    // Reset during the second ADD cycle
    bus.sum_vec   = 16'h1111;
    bus.carry_vec = 16'h2222;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    chk("mid_slice0", 32'(bus.result[3:0]), 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_result", 32'(bus.result), 32'h0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    repeat (6) tick();
    chk("abort_no_output", 32'(bus.out_valid), 32'd0);
    do_op(16'h00FF, 16'h0001, 0);

    // Random operand pairs with random idle gaps and backpressure
    for (int n = 0; n < 40; n++) begin
      rs = 16'($urandom);
      rc = 16'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      do_op(rs, rc, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
